// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchroniser, clock glitch filter, frame FSM
// with timeout and sticky error flags, feeding a first-word-fall-through FIFO.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [7:0]                    data,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          parity_err,
    output logic                          frame_err
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int FW  = $clog2(FILTER_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers; both chains idle high like the bus itself.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Glitch filter: filt_clk follows clk_s only after FILTER_LEN
    // consecutive disagreeing samples.
    // ------------------------------------------------------------------
    logic          filt_clk;
    logic          filt_clk_q;
    logic [FW-1:0] flt_cnt;
    logic          strobe;
    logic          rx_bit;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            filt_clk   <= 1'b1;
            filt_clk_q <= 1'b1;
            flt_cnt    <= '0;
        end else begin
            filt_clk_q <= filt_clk;
            if (clk_s == filt_clk) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end
        end
    end

    assign strobe = filt_clk_q & ~filt_clk;
    assign rx_bit = data_s;

    // ------------------------------------------------------------------
    // Frame FSM. shreg collects 8 data bits (LSB first) plus parity; the
    // stop bit is judged directly from rx_bit in its strobe cycle.
    // ------------------------------------------------------------------
    state_t        state;
    logic [3:0]    bitcnt;
    logic [8:0]    shreg;
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= IDLE;
            bitcnt <= '0;
            shreg  <= '0;
            to_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (strobe && !rx_bit) begin
                        state  <= RECV;
                        bitcnt <= '0;
                    end
                end
                RECV: begin
                    if (strobe) begin
                        to_cnt <= '0;
                        if (bitcnt == 4'd9) begin
                            state <= IDLE;
                        end else begin
                            shreg  <= {rx_bit, shreg[8:1]};
                            bitcnt <= bitcnt + 4'd1;
                        end
                    end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        state  <= IDLE;
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic frame_done;
    logic parity_ok;
    logic push;
    logic parity_event;
    logic stop_event;
    logic timeout_event;

    assign frame_done    = (state == RECV) && strobe && (bitcnt == 4'd9);
    assign parity_ok     = ^shreg;
    assign push          = frame_done && parity_ok && rx_bit;
    assign parity_event  = frame_done && !parity_ok;
    assign stop_event    = frame_done && parity_ok && !rx_bit;
    assign timeout_event = (state == RECV) && !strobe && (to_cnt == TW'(TIMEOUT_CYC - 1));

    // ------------------------------------------------------------------
    // FIFO. A pop frees a slot in the same cycle, so a full FIFO still
    // accepts a push when it is being read.
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] w_ptr;
    logic [AW-1:0] r_ptr;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          drop;

    assign pop     = rd_en && (count != '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    // NOTE: the storage array has no reset; occupancy is tracked by count,
    // so stale entries are never observable and the RAM can map to plain cells.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[w_ptr] <= shreg[7:0];
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            w_ptr <= '0;
            r_ptr <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                w_ptr <= w_ptr + AW'(1);
            end
            if (pop) begin
                r_ptr <= r_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign data  = mem[r_ptr];
    assign ready = (count != '0);

    // Sticky flags: a new event in the clr_err cycle leaves the flag set.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            overflow   <= drop                       | (overflow   & ~clr_err);
            parity_err <= parity_event               | (parity_err & ~clr_err);
            frame_err  <= stop_event | timeout_event | (frame_err  & ~clr_err);
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: drives PS/2 frames on the raw pins and checks
// the FIFO/flag outputs against a queue-based model every quiet cycle.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int TOUT  = 100;
    localparam int H     = 20;   // PS/2 half bit period in clk cycles

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data;
    logic       ready;
    logic [3:0] count;
    logic       overflow;
    logic       parity_err;
    logic       frame_err;

    ps2_rx_fifo #(
        .FIFO_DEPTH (DEPTH),
        .SYNC_STAGES(2),
        .FILTER_LEN (4),
        .TIMEOUT_CYC(TOUT)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .data      (data),
        .ready     (ready),
        .count     (count),
        .overflow  (overflow),
        .parity_err(parity_err),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: accepted bytes in order plus the three sticky flags.
    logic [7:0] mq[$];
    logic       m_ovf  = 1'b0;
    logic       m_par  = 1'b0;
    logic       m_frm  = 1'b0;
    logic       chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", {31'b0, ready}, {31'b0, mq.size() != 0});
            check("count", {28'b0, count}, mq.size());
            if (mq.size() != 0) check("data", {24'b0, data}, {24'b0, mq[0]});
            check("overflow",   {31'b0, overflow},   {31'b0, m_ovf});
            check("parity_err", {31'b0, parity_err}, {31'b0, m_par});
            check("frame_err",  {31'b0, frame_err},  {31'b0, m_frm});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Shifts out bits[0..nbits-1]; optional 2-cycle low glitch in the high phase of one bit.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            cyc(H);
            if (i == glitch_bit) begin
                ps2_clk = 1'b0;
                cyc(2);
                ps2_clk = 1'b1;
                cyc(H);
            end
            ps2_clk = 1'b0;
            cyc(H);
            ps2_clk = 1'b1;
        end
        cyc(H);
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop,
                              input int glitch_bit);
        logic par;
        par = ~(^d) ^ bad_par;
        chk_en = 1'b0;
        send_bits({stop, par, d, 1'b0}, 11, glitch_bit);
        cyc(20);
        if (((^d) ^ par) == 1'b0)  m_par = 1'b1;
        else if (!stop)            m_frm = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(d);
        else                       m_ovf = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic pop_one();
        chk_en = 1'b0;
        rd_en  = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
        chk_en = 1'b1;
    endtask

    task automatic clear_errors();
        chk_en  = 1'b0;
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        m_ovf = 1'b0;
        m_par = 1'b0;
        m_frm = 1'b0;
        chk_en = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        cyc(3);
        check("rst_ready", {31'b0, ready}, 0);
        check("rst_count", {28'b0, count}, 0);
        check("rst_flags", {29'b0, overflow, parity_err, frame_err}, 0);
        clrn = 1'b1;
        cyc(5);
        chk_en = 1'b1;

        // A falling edge with data high in IDLE is not a start bit.
        chk_en = 1'b0;
        send_bits(11'h7FF, 1, -1);
        cyc(20);
        chk_en = 1'b1;
        check("nostart_flags", {29'b0, overflow, parity_err, frame_err}, 0);
        check("nostart_count", {28'b0, count}, 0);

        // 1: single frame, read back, then a pop on an empty FIFO.
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        check("t1_model", {24'b0, mq[0]}, 32'h1C);
        check("t1_data",  {24'b0, data}, 32'h1C);
        check("t1_ready", {31'b0, ready}, 1);
        check("t1_count", {28'b0, count}, 1);
        pop_one();
        check("t1_ready_after", {31'b0, ready}, 0);
        check("t1_count_after", {28'b0, count}, 0);
        pop_one();
        check("t1_empty_pop", {28'b0, count}, 0);

        // 2: fill past capacity.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, -1);
        check("t2_count", {28'b0, count}, 8);
        check("t2_overflow", {31'b0, overflow}, 1);
        for (int i = 1; i <= 8; i++) begin
            check("t2_pop_data", {24'b0, data}, i);
            pop_one();
        end
        check("t2_drained", {31'b0, ready}, 0);

        // 3: parity error; clr_err clears all sticky flags.
        send_frame(8'h55, 1'b1, 1'b1, -1);
        check("t3_parity_err", {31'b0, parity_err}, 1);
        check("t3_count", {28'b0, count}, 0);
        clear_errors();
        check("t3_cleared", {29'b0, overflow, parity_err, frame_err}, 0);

        // 4: truncated frame runs into the timeout.
        chk_en = 1'b0;
        send_bits(11'b000_0000_1010, 5, -1);
        cyc(150);
        m_frm  = 1'b1;
        chk_en = 1'b1;
        check("t4_frame_err", {31'b0, frame_err}, 1);
        check("t4_count", {28'b0, count}, 0);
        send_frame(8'hF0, 1'b0, 1'b1, -1);
        check("t4_data", {24'b0, data}, 32'hF0);
        check("t4_count_after", {28'b0, count}, 1);
        clear_errors();
        pop_one();

        // Bad stop bit.
        send_frame(8'h42, 1'b0, 1'b0, -1);
        check("stop_frame_err", {31'b0, frame_err}, 1);
        check("stop_count", {28'b0, count}, 0);
        clear_errors();

        // 5: short clock glitch mid-frame is filtered out.
        send_frame(8'hAA, 1'b0, 1'b1, 4);
        check("t5_data", {24'b0, data}, 32'hAA);
        check("t5_flags", {29'b0, overflow, parity_err, frame_err}, 0);

        // 6: reset mid-frame clears everything immediately.
        send_frame(8'h33, 1'b1, 1'b1, -1);
        chk_en = 1'b0;
        send_bits({2'b11, 8'h3B, 1'b0}, 6, -1);
        clrn = 1'b0;
        #1;
        check("t6_async_ready", {31'b0, ready}, 0);
        check("t6_async_count", {28'b0, count}, 0);
        check("t6_async_flags", {29'b0, overflow, parity_err, frame_err}, 0);
        cyc(3);
        clrn = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        m_par = 1'b0;
        m_frm = 1'b0;
        cyc(5);
        chk_en = 1'b1;
        send_frame(8'h3B, 1'b0, 1'b1, -1);
        check("t6_data", {24'b0, data}, 32'h3B);
        check("t6_count", {28'b0, count}, 1);
        check("t6_flags", {29'b0, overflow, parity_err, frame_err}, 0);

        cyc(10);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
